// File: rtl/mxv_result_tx_pkg.sv
// Shared definitions for the MxV result transmitter: sizes, packet framing bytes, state type.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mxv_result_tx_pkg;

    localparam int N_MAX  = 8;    // maximum number of result elements
    localparam int RES_W  = 16;   // width of one result element (2 bytes, MSB first)
    localparam int IDX_W  = 3;    // clog2(N_MAX)
    localparam int BIDX_W = 5;    // byte index inside a packet, max 2*N_MAX+3 = 19
    localparam int NLEN_W = 4;    // width of the element count input

    localparam logic [7:0] PKT_HDR  = 8'hFE;
    localparam logic [7:0] PKT_TRL  = 8'hEF;
    localparam logic [7:0] RESP_CMD = 8'h05;

    typedef logic [RES_W-1:0] result_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } tx_state_t;

    // LEN field: payload bytes plus the command byte, 2*n+1
    function automatic logic [7:0] pkt_len(input logic [NLEN_W-1:0] n);
        return {3'b000, n, 1'b1};
    endfunction

    // Byte index of the trailer, 2*n+3
    function automatic logic [BIDX_W-1:0] last_byte_idx(input logic [NLEN_W-1:0] n);
        return {n, 1'b0} + BIDX_W'(3);
    endfunction

endpackage

// File: rtl/mxv_result_buffer.sv
// Result register file: N_MAX entries of RES_W bits, one write port, bulk clear, async reset.
// Latency: writes visible the cycle after the strobe; read is combinational by index.
// Backpressure: none; the owner gates we/clr when the contents must stay frozen.
module mxv_result_buffer
    import mxv_result_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_addr,
    input  result_t          wr_data,
    input  logic             clr,
    input  logic [IDX_W-1:0] rd_addr,
    output result_t          rd_data
);

    result_t mem_q [N_MAX];

    // Storage update: clear takes priority over a write in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MAX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N_MAX; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mxv_result_tx.sv
// Buffers MxV results and sends them as one framed packet (FE LEN 05 data.. EF) byte by byte.
// Latency: first TX_SEND one cycle after an accepted START; next byte one cycle after TX_DONE.
// Backpressure: one byte in flight; waits for TX_DONE before each next byte, ignores inputs while busy.
module mxv_result_tx
    import mxv_result_tx_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RES_WE,
    input  logic [IDX_W-1:0]  RES_ADDR,
    input  logic [RES_W-1:0]  RES_DATA,
    input  logic              CLEAR,
    input  logic              START,
    input  logic [NLEN_W-1:0] N_ELEM,
    input  logic              TX_DONE,
    output logic [7:0]        TX_BYTE,
    output logic              TX_SEND,
    output logic              BUSY,
    output logic              DONE
);

    tx_state_t          state_q, state_d;
    logic [BIDX_W-1:0]  idx_q, idx_d;
    logic [NLEN_W-1:0]  n_q, n_d;
    logic [7:0]         tx_byte_q, tx_byte_d;

    logic               in_idle;
    logic               start_ok;
    logic [3:0]         data_idx;
    logic [IDX_W-1:0]   rd_addr;
    result_t            rd_data;
    logic [7:0]         sel_byte;

    assign in_idle  = (state_q == IDLE);
    assign start_ok = START && (N_ELEM != '0) && (N_ELEM <= NLEN_W'(N_MAX));

    // Buffer contents only change while idle, so a packet in flight sees frozen data
    mxv_result_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (RES_WE && in_idle),
        .wr_addr (RES_ADDR),
        .wr_data (RES_DATA),
        .clr     (CLEAR && in_idle),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Byte selector: framing bytes by position, otherwise a result byte (even offset = MSB).
    // Data offsets never exceed 15, so the 4-bit wrap of idx-3 is harmless for framing bytes.
    always_comb begin
        data_idx = 4'(idx_q - BIDX_W'(3));
        rd_addr  = data_idx[IDX_W:1];
        sel_byte = '0;
        if (idx_q == BIDX_W'(0)) begin
            sel_byte = PKT_HDR;
        end else if (idx_q == BIDX_W'(1)) begin
            sel_byte = pkt_len(n_q);
        end else if (idx_q == BIDX_W'(2)) begin
            sel_byte = RESP_CMD;
        end else if (idx_q == last_byte_idx(n_q)) begin
            sel_byte = PKT_TRL;
        end else if (data_idx[0]) begin
            sel_byte = rd_data[7:0];
        end else begin
            sel_byte = rd_data[RES_W-1:8];
        end
    end

    // State, byte index, element count and held byte registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    // Next-state logic: TX_DONE only matters in WAIT, START only in IDLE
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    n_d     = N_ELEM;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_byte_d = sel_byte;
                state_d   = WAIT;
            end
            WAIT: begin
                if (TX_DONE) begin
                    if (idx_q == last_byte_idx(n_q)) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + BIDX_W'(1);
                        state_d = LOAD;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from the registered state; reset drives them all low at once
    assign TX_SEND = (state_q == LOAD);
    assign TX_BYTE = (state_q == LOAD) ? sel_byte : tx_byte_q;
    assign BUSY    = (state_q == LOAD) || (state_q == WAIT);
    assign DONE    = (state_q == FINISH);

endmodule
